// File: rtl/svc_rv_csr_pkg.sv
// Shared CSR definitions for the RV SoC: counter CSR addresses, perf-counter
// state encoding and the address decode used by the performance counter.
package svc_rv_csr_pkg;

    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

    typedef enum logic {
        PERF_RUN  = 1'b0,
        PERF_HALT = 1'b1
    } perf_state_t;

    typedef enum logic [2:0] {
        SEL_NONE   = 3'd0,
        SEL_CYC_LO = 3'd1,
        SEL_CYC_HI = 3'd2,
        SEL_INS_LO = 3'd3,
        SEL_INS_HI = 3'd4
    } csr_sel_t;

    // User-level and machine-level aliases map onto the same counter halves.
    function automatic csr_sel_t csr_decode(input logic [11:0] addr);
        csr_sel_t sel;
        sel = SEL_NONE;
        case (addr)
            CSR_CYCLE,    CSR_MCYCLE:    sel = SEL_CYC_LO;
            CSR_CYCLEH,   CSR_MCYCLEH:   sel = SEL_CYC_HI;
            CSR_INSTRET,  CSR_MINSTRET:  sel = SEL_INS_LO;
            CSR_INSTRETH, CSR_MINSTRETH: sel = SEL_INS_HI;
            default:                     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/svc_rv_perf_ctr64.sv
// 64-bit event counter with a high-half shadow so that a low read followed by
// a high read returns a coherent 64-bit value even across a carry.
module svc_rv_perf_ctr64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    input  logic        snap_ld,
    input  logic        hi_rd,
    output logic [31:0] lo_rdata,
    output logic [31:0] hi_rdata
);

    logic [63:0] cnt_q,    cnt_d;
    logic [31:0] shadow_q, shadow_d;
    logic        snap_v_q, snap_v_d;

    // Clear outranks increment and snapshot load; a high read consumes the shadow.
    always_comb begin
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        snap_v_d = snap_v_q;
        if (clr) begin
            cnt_d    = 64'd0;
            shadow_d = 32'd0;
            snap_v_d = 1'b0;
        end else begin
            if (inc) begin
                cnt_d = cnt_q + 64'd1;
            end
            if (snap_ld) begin
                shadow_d = cnt_q[63:32];
                snap_v_d = 1'b1;
            end else if (hi_rd) begin
                snap_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 64'd0;
            shadow_q <= 32'd0;
            snap_v_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            snap_v_q <= snap_v_d;
        end
    end

    assign lo_rdata = cnt_q[31:0];
    assign hi_rdata = snap_v_q ? shadow_q : cnt_q[63:32];

endmodule

// File: rtl/svc_rv_perf_cnt.sv
// Cycle / retired-instruction performance counter serving the cycle and
// instret CSRs; counting freezes on ebreak until clr or reset.
module svc_rv_perf_cnt
    import svc_rv_csr_pkg::*;
#(
    parameter int CSR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        retire,
    input  logic        ebreak,
    input  logic        clr,
    input  logic        csr_en,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_rdata,
    output logic        csr_hit,
    output logic        halted
);

    perf_state_t state_q, state_d;
    csr_sel_t    sel;
    logic        run;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    logic [31:0] rdata_q, rdata_d;
    logic        hit_q, hit_d;

    assign sel = csr_decode(csr_addr);
    assign run = (state_q == PERF_RUN);

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = PERF_RUN;
        end else if (run && ebreak) begin
            state_d = PERF_HALT;
        end
    end

    svc_rv_perf_ctr64 u_cyc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (run),
        .snap_ld  (csr_en && (sel == SEL_CYC_LO)),
        .hi_rd    (csr_en && (sel == SEL_CYC_HI)),
        .lo_rdata (cyc_lo),
        .hi_rdata (cyc_hi)
    );

    svc_rv_perf_ctr64 u_ins (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (run && retire),
        .snap_ld  (csr_en && (sel == SEL_INS_LO)),
        .hi_rd    (csr_en && (sel == SEL_INS_HI)),
        .lo_rdata (ins_lo),
        .hi_rdata (ins_hi)
    );

    // Read data is taken from pre-edge counter values, so a read alongside clr sees pre-clear state.
    always_comb begin
        rdata_d = 32'd0;
        hit_d   = 1'b0;
        if (csr_en) begin
            hit_d = (sel != SEL_NONE);
            case (sel)
                SEL_CYC_LO: rdata_d = cyc_lo;
                SEL_CYC_HI: rdata_d = cyc_hi;
                SEL_INS_LO: rdata_d = ins_lo;
                SEL_INS_HI: rdata_d = ins_hi;
                default:    rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PERF_RUN;
            rdata_q <= 32'd0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            hit_q   <= hit_d;
        end
    end

    assign csr_rdata = rdata_q;
    assign csr_hit   = hit_q;
    assign halted    = (state_q == PERF_HALT);

endmodule

// File: tb/tb_svc_rv_perf_cnt.sv
// Directed self-checking bench for svc_rv_perf_cnt with hand-computed expectations.
module tb_svc_rv_perf_cnt;

    logic        clk;
    logic        rst_n;
    logic        retire;
    logic        ebreak;
    logic        clr;
    logic        csr_en;
    logic [11:0] csr_addr;
    logic [31:0] csr_rdata;
    logic        csr_hit;
    logic        halted;

    int vectors;
    int miscompares;

    svc_rv_perf_cnt #(.CSR_LAT(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .retire    (retire),
        .ebreak    (ebreak),
        .clr       (clr),
        .csr_en    (csr_en),
        .csr_addr  (csr_addr),
        .csr_rdata (csr_rdata),
        .csr_hit   (csr_hit),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issues a one-cycle read at a negedge and samples the result just after the next posedge.
    task automatic do_read(input logic [11:0] addr, output logic [31:0] data, output logic hit);
        @(negedge clk);
        csr_en   = 1'b1;
        csr_addr = addr;
        @(posedge clk);
        #1;
        data   = csr_rdata;
        hit    = csr_hit;
        csr_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        h;
        #3;
        vectors++;
        if (csr_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_rdata: got %h expected %h", csr_rdata, 32'd0);
        end
        vectors++;
        if ({csr_hit, halted} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_hit_halted: got %b expected %b", {csr_hit, halted}, 2'b00);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        do_read(12'hC00, d, h);
        vectors++;
        if (d !== 32'd10) begin
            miscompares++;
            $display("[TB] FAIL free_run_cyc: got %0d expected %0d", d, 10);
        end
        vectors++;
        if (h !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL free_run_hit: got %b expected %b", h, 1'b1);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({csr_hit, csr_rdata} !== 33'd0) begin
            miscompares++;
            $display("[TB] FAIL idle_clears_output: got hit=%b data=%h expected hit=0 data=0", csr_hit, csr_rdata);
        end
    endtask

    task automatic test_retire_halt;
        logic [31:0] d;
        logic        h;
        @(negedge clk);
        clr = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clr    = 1'b0;
            retire = 1'b1;
            @(negedge clk);
            retire = 1'b0;
        end
        @(negedge clk);
        retire = 1'b1;
        ebreak = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        ebreak = 1'b0;
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_after_ebreak: got %b expected %b", halted, 1'b1);
        end
        do_read(12'hC02, d, h);
        vectors++;
        if (d !== 32'd8) begin
            miscompares++;
            $display("[TB] FAIL instret_count: got %0d expected %0d", d, 8);
        end
        do_read(12'hB00, d, h);
        vectors++;
        if (d !== 32'd15 || h !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mcycle_frozen: got %0d hit=%b expected %0d hit=1", d, h, 15);
        end
        @(negedge clk);
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        repeat (20) @(posedge clk);
        do_read(12'hC00, d, h);
        vectors++;
        if (d !== 32'd15) begin
            miscompares++;
            $display("[TB] FAIL cycle_still_frozen: got %0d expected %0d", d, 15);
        end
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_persists: got %b expected %b", halted, 1'b1);
        end
    endtask

    task automatic test_coherent_high;
        logic [31:0] d;
        logic        h;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        dut.u_cyc.cnt_q <= 64'h0000_0000_FFFF_FFFE;
        csr_en   = 1'b1;
        csr_addr = 12'hC00;
        @(posedge clk);
        #1;
        csr_en = 1'b0;
        vectors++;
        if (csr_rdata !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("[TB] FAIL coherent_low: got %h expected %h", csr_rdata, 32'hFFFF_FFFE);
        end
        repeat (2) @(posedge clk);
        do_read(12'hC80, d, h);
        vectors++;
        if (d !== 32'h0000_0000) begin
            miscompares++;
            $display("[TB] FAIL coherent_high_shadow: got %h expected %h", d, 32'h0);
        end
        do_read(12'hB80, d, h);
        vectors++;
        if (d !== 32'h0000_0001) begin
            miscompares++;
            $display("[TB] FAIL live_high_after_shadow: got %h expected %h", d, 32'h1);
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        logic        h;
        @(negedge clk);
        dut.u_ins.cnt_q <= 64'hFFFF_FFFF_FFFF_FFFF;
        retire = 1'b1;
        @(negedge clk);
        retire = 1'b0;
        do_read(12'hC82, d, h);
        vectors++;
        if (d !== 32'd0 || h !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wrap_high: got %h hit=%b expected 00000000 hit=1", d, h);
        end
        do_read(12'hC02, d, h);
        vectors++;
        if (d !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL wrap_low: got %h expected %h", d, 32'd0);
        end
    endtask

    task automatic test_unsupported_and_clr;
        logic [31:0] d;
        logic        h;
        do_read(12'h300, d, h);
        vectors++;
        if (d !== 32'd0 || h !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL unsupported_addr: got %h hit=%b expected 00000000 hit=0", d, h);
        end
        @(negedge clk);
        retire = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        clr      = 1'b1;
        ebreak   = 1'b1;
        csr_en   = 1'b1;
        csr_addr = 12'hC02;
        @(posedge clk);
        #1;
        vectors++;
        if (csr_rdata !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL read_with_clr_preclear: got %0d expected %0d", csr_rdata, 3);
        end
        @(negedge clk);
        clr      = 1'b0;
        ebreak   = 1'b0;
        retire   = 1'b0;
        csr_addr = 12'hC00;
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_beats_ebreak: got halted=%b expected halted=0", halted);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (csr_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_cycle_zero: got %0d expected %0d", csr_rdata, 0);
        end
        @(negedge clk);
        csr_addr = 12'hC02;
        @(posedge clk);
        #1;
        csr_en = 1'b0;
        vectors++;
        if (csr_rdata !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL clr_instret_zero: got %0d expected %0d", csr_rdata, 0);
        end
    endtask

    task automatic test_reset_mid_read;
        @(negedge clk);
        ebreak = 1'b1;
        @(negedge clk);
        ebreak   = 1'b0;
        csr_en   = 1'b1;
        csr_addr = 12'hC00;
        @(posedge clk);
        #1;
        vectors++;
        if ({csr_hit, halted} !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_state: got hit,halted=%b expected %b", {csr_hit, halted}, 2'b11);
        end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (csr_rdata !== 32'd0 || csr_hit !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_read: got %h hit=%b expected 00000000 hit=0", csr_rdata, csr_hit);
        end
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_halted: got %b expected %b", halted, 1'b0);
        end
        csr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        retire      = 1'b0;
        ebreak      = 1'b0;
        clr         = 1'b0;
        csr_en      = 1'b0;
        csr_addr    = 12'h000;
        $display("[TB] starting svc_rv_perf_cnt bench");
        test_reset();
        test_retire_halt();
        test_coherent_high();
        test_wrap();
        test_unsupported_and_clr();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
